// File: rtl/mem_addr_arb.sv
// Memory address source selector: grants one of NCH requesters at a time and holds
// its address registered on the memory bus until mem_ready. Optional macro ARB_FIXED_PRIO_EN.
module mem_addr_arb #(
    parameter int WIDTH = 12,
    parameter int NCH   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*WIDTH-1:0] addr_in,
    input  logic                 mem_ready,
    output logic [WIDTH-1:0]     addr_out,
    output logic                 mem_valid,
    output logic [NCH-1:0]       grant,
    output logic [NCH-1:0]       done,
    output logic                 busy
);

    localparam int            PW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [PW-1:0] LAST = PW'(NCH - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state_r;
    logic [NCH-1:0]   eligible_s;
    logic [NCH-1:0]   win_onehot_s;
    logic             win_found_s;
    logic [PW-1:0]    win_idx_s;
    logic [WIDTH-1:0] win_addr_s;
`ifndef ARB_FIXED_PRIO_EN
    logic [PW-1:0]    ptr_r;
    logic [PW-1:0]    owner_r;
    logic [PW-1:0]    cand_s;
`endif

    // Winner search; a channel pulsing done this cycle is not eligible.
    always_comb begin
        eligible_s  = req & ~done;
        win_found_s = 1'b0;
        win_idx_s   = '0;
`ifdef ARB_FIXED_PRIO_EN
        for (int i = 0; i < NCH; i++) begin
            if (!win_found_s && eligible_s[i]) begin
                win_found_s = 1'b1;
                win_idx_s   = PW'(i);
            end else begin
                win_found_s = win_found_s;
            end
        end
`else
        // Walk ptr, ptr+1, ... with an explicit wrap so non-power-of-two NCH works.
        cand_s = ptr_r;
        for (int k = 0; k < NCH; k++) begin
            if (!win_found_s && eligible_s[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
            if (cand_s == LAST) begin
                cand_s = '0;
            end else begin
                cand_s = cand_s + 1'b1;
            end
        end
`endif
    end

    // Address mux and one-hot grant for the winning channel.
    always_comb begin
        win_addr_s   = '0;
        win_onehot_s = '0;
        for (int i = 0; i < NCH; i++) begin
            if (win_found_s && (win_idx_s == PW'(i))) begin
                win_addr_s      = addr_in[i*WIDTH +: WIDTH];
                win_onehot_s[i] = 1'b1;
            end else begin
                win_onehot_s[i] = 1'b0;
            end
        end
    end

    // Access FSM; all bus-side outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            addr_out  <= '0;
            mem_valid <= 1'b0;
            grant     <= '0;
            done      <= '0;
            busy      <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            ptr_r     <= '0;
            owner_r   <= '0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done <= '0;
                    if (win_found_s) begin
                        addr_out  <= win_addr_s;
                        grant     <= win_onehot_s;
                        mem_valid <= 1'b1;
                        busy      <= 1'b1;
                        state_r   <= BUSY;
`ifndef ARB_FIXED_PRIO_EN
                        owner_r   <= win_idx_s;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    // Inputs are ignored here; only mem_ready ends the access.
                    if (mem_ready) begin
                        done      <= grant;
                        grant     <= '0;
                        addr_out  <= '0;
                        mem_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
`ifndef ARB_FIXED_PRIO_EN
                        ptr_r     <= (owner_r == LAST) ? '0 : owner_r + 1'b1;
`endif
                    end else begin
                        done <= '0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    grant     <= '0;
                    done      <= '0;
                    mem_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_addr_arb.sv
// Self-checking bench for mem_addr_arb: vector table, hand sequences, randomized run
// against a behavioural model, and a three-channel rotation check.
module tb_mem_addr_arb;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [11:0] a0, a1;
    logic        rdy;
    logic [11:0] addr_out;
    logic        mem_valid, busy;
    logic [1:0]  grant, done;

    logic [2:0]  req3;
    logic [35:0] addr3;
    logic        rdy3;
    logic [11:0] addr_out3;
    logic        mem_valid3, busy3;
    logic [2:0]  grant3, done3;

    int n_pass, n_total;

    // behavioural model state for the two-channel instance
    bit          m_busy;
    int          m_own, m_ptr;
    logic [1:0]  m_grant, m_done;
    logic [11:0] m_addr;

    typedef struct {
        logic [1:0]  req;
        logic [11:0] a0;
        logic [11:0] a1;
        logic        rdy;
        logic [1:0]  eg;
        logic [11:0] ea;
        logic        ev;
        logic [1:0]  ed;
    } vec_t;
    vec_t tbl[10];
    logic [2:0] exp3[4];

    mem_addr_arb #(.WIDTH(12), .NCH(2)) dut (
        .clk(clk), .rst(rst), .req(req), .addr_in({a1, a0}), .mem_ready(rdy),
        .addr_out(addr_out), .mem_valid(mem_valid), .grant(grant), .done(done), .busy(busy)
    );

    mem_addr_arb #(.WIDTH(12), .NCH(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .addr_in(addr3), .mem_ready(rdy3),
        .addr_out(addr_out3), .mem_valid(mem_valid3), .grant(grant3), .done(done3), .busy(busy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        m_busy  = 1'b0;
        m_own   = 0;
        m_ptr   = 0;
        m_grant = 2'b00;
        m_done  = 2'b00;
        m_addr  = 12'h000;
    endtask

    // One clock edge of the arbiter described by its rules, using the inputs seen at the edge.
    task automatic mdl_edge();
        logic [1:0] elig;
        int c;
        bit found;
        if (!m_busy) begin
            elig   = req & ~m_done;
            m_done = 2'b00;
            found  = 1'b0;
            for (int k = 0; k < 2; k++) begin
`ifdef ARB_FIXED_PRIO_EN
                c = k;
`else
                c = (m_ptr + k) % 2;
`endif
                if (!found && elig[c]) begin
                    found = 1'b1;
                    m_own = c;
                end
            end
            if (found) begin
                m_busy  = 1'b1;
                m_grant = 2'b01 << m_own;
                m_addr  = (m_own == 0) ? a0 : a1;
            end
        end else if (rdy) begin
            m_busy  = 1'b0;
            m_done  = m_grant;
            m_grant = 2'b00;
            m_addr  = 12'h000;
            m_ptr   = (m_own + 1) % 2;
        end else begin
            m_done = 2'b00;
        end
    endtask

    task automatic step();
        @(posedge clk);
        mdl_edge();
        #1;
        chk("mdl_grant", 32'(grant), 32'(m_grant));
        chk("mdl_done", 32'(done), 32'(m_done));
        chk("mdl_addr", 32'(addr_out), 32'(m_addr));
        chk("mdl_valid", 32'(mem_valid), 32'(m_busy));
        chk("mdl_busy", 32'(busy), 32'(m_busy));
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs checked before any edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_valid", 32'(mem_valid), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_addr", 32'(addr_out), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant3", 32'(grant3), 32'd0);
        mdl_reset();
        #2;
        rst = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst  = 1'b0;
        req  = 2'b00;
        a0   = 12'h000;
        a1   = 12'h000;
        rdy  = 1'b0;
        req3 = 3'b000;
        addr3 = {12'h333, 12'h222, 12'h111};
        rdy3 = 1'b0;
        mdl_reset();

        tbl[0] = '{2'b01, 12'h123, 12'h000, 1'b0, 2'b01, 12'h123, 1'b1, 2'b00};
        tbl[1] = '{2'b00, 12'h123, 12'h000, 1'b0, 2'b01, 12'h123, 1'b1, 2'b00};
        tbl[2] = '{2'b00, 12'h123, 12'h000, 1'b1, 2'b00, 12'h000, 1'b0, 2'b01};
        tbl[3] = '{2'b00, 12'h123, 12'h000, 1'b0, 2'b00, 12'h000, 1'b0, 2'b00};
`ifdef ARB_FIXED_PRIO_EN
        tbl[4] = '{2'b11, 12'h0AA, 12'h555, 1'b1, 2'b01, 12'h0AA, 1'b1, 2'b00};
        tbl[5] = '{2'b11, 12'h0AA, 12'h555, 1'b1, 2'b00, 12'h000, 1'b0, 2'b01};
        tbl[6] = '{2'b11, 12'h0AA, 12'h555, 1'b1, 2'b10, 12'h555, 1'b1, 2'b00};
        tbl[7] = '{2'b11, 12'h0AA, 12'h555, 1'b1, 2'b00, 12'h000, 1'b0, 2'b10};
        tbl[8] = '{2'b11, 12'h0AA, 12'h555, 1'b1, 2'b01, 12'h0AA, 1'b1, 2'b00};
        tbl[9] = '{2'b11, 12'h0AA, 12'h555, 1'b1, 2'b00, 12'h000, 1'b0, 2'b01};
        exp3[0] = 3'b001; exp3[1] = 3'b010; exp3[2] = 3'b001; exp3[3] = 3'b010;
`else
        // ch0 was just served, so the pointer starts contention at ch1
        tbl[4] = '{2'b11, 12'h0AA, 12'h555, 1'b1, 2'b10, 12'h555, 1'b1, 2'b00};
        tbl[5] = '{2'b11, 12'h0AA, 12'h555, 1'b1, 2'b00, 12'h000, 1'b0, 2'b10};
        tbl[6] = '{2'b11, 12'h0AA, 12'h555, 1'b1, 2'b01, 12'h0AA, 1'b1, 2'b00};
        tbl[7] = '{2'b11, 12'h0AA, 12'h555, 1'b1, 2'b00, 12'h000, 1'b0, 2'b01};
        tbl[8] = '{2'b11, 12'h0AA, 12'h555, 1'b1, 2'b10, 12'h555, 1'b1, 2'b00};
        tbl[9] = '{2'b11, 12'h0AA, 12'h555, 1'b1, 2'b00, 12'h000, 1'b0, 2'b10};
        exp3[0] = 3'b001; exp3[1] = 3'b010; exp3[2] = 3'b100; exp3[3] = 3'b001;
`endif

        do_reset();

        for (int i = 0; i < 10; i++) begin
            req = tbl[i].req;
            a0  = tbl[i].a0;
            a1  = tbl[i].a1;
            rdy = tbl[i].rdy;
            step();
            chk("tbl_grant", 32'(grant), 32'(tbl[i].eg));
            chk("tbl_addr", 32'(addr_out), 32'(tbl[i].ea));
            chk("tbl_valid", 32'(mem_valid), 32'(tbl[i].ev));
            chk("tbl_done", 32'(done), 32'(tbl[i].ed));
        end

        // address and grant stay frozen while inputs move during BUSY
        req = 2'b00; rdy = 1'b0;
        step();
        req = 2'b10; a1 = 12'h7FF;
        step();
        chk("stab_grant0", 32'(grant), 32'h2);
        a1 = 12'h001; req = 2'b00;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stab_addr", 32'(addr_out), 32'h7FF);
            chk("stab_grant", 32'(grant), 32'h2);
        end
        rdy = 1'b1;
        step();
        chk("stab_done", 32'(done), 32'h2);

        // mem_ready with nothing in flight is ignored
        for (int i = 0; i < 3; i++) begin
            step();
            chk("spur_done", 32'(done), 32'h0);
            chk("spur_grant", 32'(grant), 32'h0);
        end
        req = 2'b11; rdy = 1'b0;
        step();
        chk("spur_next_grant", 32'(grant), 32'h1);
        rdy = 1'b1;
        step();
        chk("spur_next_done", 32'(done), 32'h1);

        // reset in the middle of an access on ch1
        req = 2'b10; rdy = 1'b0;
        step();
        chk("mid_pre_grant", 32'(grant), 32'h2);
        do_reset();
        req = 2'b11;
        step();
        chk("post_rst_grant", 32'(grant), 32'h1);
        chk("post_rst_addr", 32'(addr_out), 32'(a0));
        rdy = 1'b1;
        step();

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            req = 2'($urandom_range(0, 3));
            a0  = 12'($urandom);
            a1  = 12'($urandom);
            rdy = 1'($urandom_range(0, 1));
            step();
        end

        // three-channel rotation with all requests held
        req = 2'b00; rdy = 1'b0;
        do_reset();
        req3 = 3'b111; rdy3 = 1'b1;
        for (int s = 0; s < 8; s++) begin
            step();
            if (s % 2 == 0) begin
                chk("nch3_grant", 32'(grant3), 32'(exp3[s / 2]));
                chk("nch3_valid", 32'(mem_valid3), 32'd1);
            end else begin
                chk("nch3_done", 32'(done3), 32'(exp3[s / 2]));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
